// File: rtl/id_ex_pipe_if.sv
// ----------------------------------------------------------------------------
// id_ex_pipe_if
// Handshake and bundle bus between the decode stage and the ID/EX pipeline
// register, and between the ID/EX register and the execute stage.
//
// Signals:
//   in_valid  - decode presents a bundle
//   in_ready  - pipeline register can accept a bundle
//   in_data   - decode datapath bundle (DATA_W bits)
//   in_ctrl   - decode control bundle (CTRL_W bits)
//   flush     - discard all held and incoming bundles this cycle
//   out_valid - execute-side bundle valid
//   out_ready - execute stage consumes the bundle
//   out_data  - registered datapath bundle
//   out_ctrl  - registered control bundle, reset value while out_valid is low
//
// Modports:
//   master - the surrounding pipeline (decode/execute/hazard unit side)
//   slave  - the ID/EX pipeline register itself
// ----------------------------------------------------------------------------
interface id_ex_pipe_if #(
  parameter int DATA_W = 134,
  parameter int CTRL_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, flush, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/id_ex_pipe.sv
// ----------------------------------------------------------------------------
// id_ex_pipe
// ID/EX pipeline register with a two-entry skid buffer (main + skid).
// Carries a datapath bundle and a control bundle from decode to execute with
// a valid/ready handshake, a synchronous flush for branch mispredicts, and
// bubble insertion whenever nothing valid is held. While out_valid is low the
// control bundle always reads CTRL_RST, so a bubble can never write a
// register or memory.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - id_ex_pipe_if.slave (in_valid/in_ready/in_data/in_ctrl, flush,
//          out_valid/out_ready/out_data/out_ctrl)
//   bubble_cnt, stall_cnt - 32-bit performance counters, present only when
//          the macro ID_EX_PERF_CNT_EN is defined
//
// Configuration:
//   ID_EX_PERF_CNT_EN - when defined, adds bubble_cnt (cycles with out_valid
//   low) and stall_cnt (cycles with out_valid high and out_ready low). Both
//   wrap and are not cleared by flush.
// ----------------------------------------------------------------------------
module id_ex_pipe #(
  parameter int                DATA_W   = 134,
  parameter int                CTRL_W   = 8,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
  input  logic               clk,
  input  logic               rst,
  id_ex_pipe_if.slave        bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]        bubble_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] sk_data_q, sk_data_d;
  logic [CTRL_W-1:0] sk_ctrl_q, sk_ctrl_d;

  logic acc;
  logic pop;

  // in_ready is a flop, so acceptance never depends combinationally on the
  // execute stage's out_ready.
  assign acc = bus.in_valid & in_ready_q;
  assign pop = out_valid_q & bus.out_ready;

  // Next-state logic for the main/skid pair. Default is to hold everything;
  // the main entry's control drops to CTRL_RST whenever main empties so the
  // registered out_ctrl already reads as a bubble.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    ctrl_d    = ctrl_q;
    sk_data_d = sk_data_q;
    sk_ctrl_d = sk_ctrl_q;

    case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d = ONE;
          data_d  = bus.in_data;
          ctrl_d  = bus.in_ctrl;
        end
      end
      ONE: begin
        if (acc && pop) begin
          data_d = bus.in_data;
          ctrl_d = bus.in_ctrl;
        end else if (acc) begin
          state_d   = FULL;
          sk_data_d = bus.in_data;
          sk_ctrl_d = bus.in_ctrl;
        end else if (pop) begin
          state_d = EMPTY;
          ctrl_d  = CTRL_RST;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can move the state.
        if (pop) begin
          state_d = ONE;
          data_d  = sk_data_q;
          ctrl_d  = sk_ctrl_q;
        end
      end
      default: begin
        state_d = EMPTY;
        ctrl_d  = CTRL_RST;
      end
    endcase

    // Flush drops both entries and anything accepted this cycle. out_data
    // keeps its last value so it stays deterministic; only control is zeroed.
    if (bus.flush) begin
      state_d   = EMPTY;
      data_d    = data_q;
      ctrl_d    = CTRL_RST;
      sk_data_d = sk_data_q;
      sk_ctrl_d = sk_ctrl_q;
    end

    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  // State and bundle registers; reset empties the stage immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      data_q      <= '0;
      ctrl_q      <= CTRL_RST;
      sk_data_q   <= '0;
      sk_ctrl_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      sk_data_q   <= sk_data_d;
      sk_ctrl_q   <= sk_ctrl_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_ctrl  = ctrl_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counters wrap naturally at 32 bits; flush intentionally leaves them alone.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q + {31'd0, ~out_valid_q};
    stall_cnt_d  = stall_cnt_q + {31'd0, out_valid_q & ~bus.out_ready};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule
